// File: rtl/alu_seq_if.sv
// Execute-stage operand, control and result bundle between the core and alu_seq.
// The core drives the master side; alu_seq is the slave.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      func3;
  logic            instr30;
  logic            instr25;
  logic [1:0]      alu_op;
  logic            op2_sel;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] alu_out;
  logic            busy;

  modport master (
    output in_valid, op1, op2, func3, instr30, instr25, alu_op, op2_sel, flush,
    input  in_ready, out_valid, alu_out, busy
  );

  modport slave (
    input  in_valid, op1, op2, func3, instr30, instr25, alu_op, op2_sel, flush,
    output in_ready, out_valid, alu_out, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle RV32I/M execute ALU: registered base ops, two-cycle multiply,
// fixed-latency restoring divide with sign fix-up, valid/ready handshake and flush.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CNT_W   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q;
  logic               out_valid_q;
  logic [XLEN-1:0]    alu_out_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [1:0]         f_q;
  logic [XLEN-1:0]    a_q;
  logic [XLEN-1:0]    b_q;
  logic [XLEN-1:0]    quo_q;
  logic [XLEN-1:0]    rem_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               dz_q;

  logic               accept;
  logic               func7;
  logic               is_mop;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    base_res;

  assign accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign func7  = bus.instr30 && (bus.func3 == 3'd5 || !bus.op2_sel);
  assign is_mop = (bus.alu_op == 2'b01) && !bus.op2_sel && bus.instr25;
  assign shamt  = bus.op2[SHAMT_W-1:0];

  always_comb begin
    // NOTE: default assignment first, so every path drives base_res and no latch is inferred.
    base_res = bus.op1 + bus.op2;
    if (bus.alu_op == 2'b10) begin
      base_res = bus.op2;
    end else if (bus.alu_op == 2'b01) begin
      case ({func7, bus.func3})
        4'b1000: base_res = bus.op1 - bus.op2;
        4'b0100: base_res = bus.op1 ^ bus.op2;
        4'b0110: base_res = bus.op1 | bus.op2;
        4'b0111: base_res = bus.op1 & bus.op2;
        4'b0001: base_res = bus.op1 << shamt;
        4'b0101: base_res = bus.op1 >> shamt;
        4'b1101: base_res = $unsigned($signed(bus.op1) >>> shamt);
        4'b0010: base_res = {{(XLEN-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
        4'b0011: base_res = {{(XLEN-1){1'b0}}, bus.op1 < bus.op2};
        default: ;
      endcase
    end
  end

  // Divide operands are captured as magnitudes; signs are reapplied in FIX.
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign a_neg = !bus.func3[0] && bus.op1[XLEN-1];
  assign b_neg = !bus.func3[0] && bus.op2[XLEN-1];
  assign a_mag = a_neg ? -bus.op1 : bus.op1;
  assign b_mag = b_neg ? -bus.op2 : bus.op2;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] rem_d;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign quo_d    = {quo_q[XLEN-2:0], !rem_diff[XLEN]};
  assign rem_d    = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];

  logic [XLEN-1:0] div_res;

  always_comb begin
    div_res = f_q[1] ? (r_neg_q ? -rem_q : rem_q) : (q_neg_q ? -quo_q : quo_q);
    if (dz_q) div_res = f_q[1] ? a_q : '1;
  end

  // Sign-extending to 2*XLEN makes the truncated product exact for every signedness mix.
  logic              a_sx;
  logic              b_sx;
  logic [2*XLEN-1:0] a_w;
  logic [2*XLEN-1:0] b_w;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign a_sx    = f_q != 2'b11;
  assign b_sx    = f_q == 2'b01;
  assign a_w     = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q};
  assign b_w     = {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
  assign prod    = a_w * b_w;
  assign mul_res = (f_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every flop samples the values from before the edge.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      cnt_q       <= '0;
    end else if (bus.flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!is_mop) begin
              alu_out_q   <= base_res;
              out_valid_q <= 1'b1;
            end else if (bus.func3[2]) begin
              state_q <= S_DIV;
              cnt_q   <= CNT_W'(XLEN);
            end else begin
              state_q <= S_MUL;
            end
          end
        end
        S_MUL: begin
          alu_out_q   <= mul_res;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_DIV: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          alu_out_q   <= div_res;
          out_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (accept && is_mop) begin
      f_q <= bus.func3[1:0];
      a_q <= bus.op1;
      if (bus.func3[2]) begin
        b_q     <= b_mag;
        quo_q   <= a_mag;
        rem_q   <= '0;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        dz_q    <= bus.op2 == '0;
      end else begin
        b_q <= bus.op2;
      end
    end else if (state_q == S_DIV) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.busy      = state_q != S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed and model-checked bench for alu_seq at XLEN 32, 8 and 64.
// All three instances share operand/control stimulus; each has its own in_valid.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] op1, op2;
  logic [2:0]  func3;
  logic        instr30, instr25, op2_sel, flush;
  logic [1:0]  alu_op;
  logic        v32, v8, v64;

  alu_seq_if #(.XLEN(32)) b32 ();
  alu_seq_if #(.XLEN(8))  b8 ();
  alu_seq_if #(.XLEN(64)) b64 ();

  assign b32.in_valid = v32;  assign b8.in_valid = v8;  assign b64.in_valid = v64;
  assign b32.op1 = op1[31:0]; assign b8.op1 = op1[7:0]; assign b64.op1 = op1;
  assign b32.op2 = op2[31:0]; assign b8.op2 = op2[7:0]; assign b64.op2 = op2;
  assign b32.func3 = func3;     assign b8.func3 = func3;     assign b64.func3 = func3;
  assign b32.instr30 = instr30; assign b8.instr30 = instr30; assign b64.instr30 = instr30;
  assign b32.instr25 = instr25; assign b8.instr25 = instr25; assign b64.instr25 = instr25;
  assign b32.alu_op = alu_op;   assign b8.alu_op = alu_op;   assign b64.alu_op = alu_op;
  assign b32.op2_sel = op2_sel; assign b8.op2_sel = op2_sel; assign b64.op2_sel = op2_sel;
  assign b32.flush = flush;     assign b8.flush = flush;     assign b64.flush = flush;

  alu_seq #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  alu_seq #(.XLEN(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  alu_seq #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input int w, output logic ov, output logic rdy, output logic bsy,
                      output logic [63:0] res);
    case (w)
      8:       begin ov = b8.out_valid;  rdy = b8.in_ready;  bsy = b8.busy;  res = {56'd0, b8.alu_out}; end
      64:      begin ov = b64.out_valid; rdy = b64.in_ready; bsy = b64.busy; res = b64.alu_out; end
      default: begin ov = b32.out_valid; rdy = b32.in_ready; bsy = b32.busy; res = {32'd0, b32.alu_out}; end
    endcase
  endtask

  task automatic set_valid(input int w, input logic v);
    case (w)
      8:       v8  = v;
      64:      v64 = v;
      default: v32 = v;
    endcase
  endtask

  task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic i30,
                        input logic i25, input logic sel, input logic [63:0] a, input logic [63:0] b);
    alu_op = aop; func3 = f3; instr30 = i30; instr25 = i25; op2_sel = sel; op1 = a; op2 = b;
  endtask

  // Presents one op, then counts negedges until out_valid (lat) and in_ready-low samples (nrdy).
  task automatic run_op(input int w, input logic [1:0] aop, input logic [2:0] f3, input logic i30,
                        input logic i25, input logic sel, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output int nrdy);
    logic ov, rdy, bsy;
    @(negedge clk);
    set_op(aop, f3, i30, i25, sel, a, b);
    set_valid(w, 1'b1);
    lat = 0; nrdy = 0; ov = 1'b0; res = '0;
    while (!ov && lat < 200) begin
      @(negedge clk);
      if (lat == 0) set_valid(w, 1'b0);
      lat++;
      peek(w, ov, rdy, bsy, res);
      if (!rdy) nrdy++;
    end
    if (!ov) lat = -1;
  endtask

  task automatic exec(input string tag, input int w, input logic [1:0] aop, input logic [2:0] f3,
                      input logic i30, input logic i25, input logic sel, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
    logic [63:0] res;
    int lat, nrdy;
    run_op(w, aop, f3, i30, i25, sel, a, b, res, lat, nrdy);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [127:0] sx(input logic [63:0] x, input int w);
    logic [63:0] t;
    t = x[w-1] ? (x | ~wmask(w)) : (x & wmask(w));
    return $signed({{64{t[63]}}, t});
  endfunction

  // Reference model built on native wide arithmetic, masked to the instance width.
  function automatic logic [63:0] ref_alu(input int w, input logic [1:0] aop, input logic [2:0] f3,
                                          input logic i30, input logic i25, input logic sel,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] m, a, b, r, msb;
    logic signed [127:0] sa, sb, p;
    logic [127:0] ua, ub, up;
    logic f7;
    int sh;
    m = wmask(w); a = a_in & m; b = b_in & m; msb = 64'd1 << (w - 1);
    sa = sx(a, w); sb = sx(b, w); ua = {64'd0, a}; ub = {64'd0, b};
    f7 = i30 && (f3 == 3'd5 || !sel);
    sh = int'(b & 64'(w - 1));
    r = a + b;
    if (aop == 2'b10) begin
      r = b;
    end else if (aop == 2'b01 && !sel && i25) begin
      case (f3)
        3'd0: begin p = sa * sb; r = p[63:0]; end
        3'd1: begin p = sa * sb; up = p >> w; r = up[63:0]; end
        3'd2: begin p = sa * $signed(ub); up = p >> w; r = up[63:0]; end
        3'd3: begin up = ua * ub; up = up >> w; r = up[63:0]; end
        3'd4: r = (b == 0) ? m : (a == msb && b == m) ? a : 64'(sa / sb);
        3'd5: r = (b == 0) ? m : a / b;
        3'd6: r = (b == 0) ? a : (a == msb && b == m) ? 64'd0 : 64'(sa % sb);
        default: r = (b == 0) ? a : a % b;
      endcase
    end else if (aop == 2'b01) begin
      case ({f7, f3})
        4'b1000: r = a - b;
        4'b0100: r = a ^ b;
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        4'b0001: r = a << sh;
        4'b0101: r = a >> sh;
        4'b1101: r = 64'(sa >>> sh);
        4'b0010: r = {63'd0, sa < sb};
        4'b0011: r = {63'd0, a < b};
        default: ;
      endcase
    end
    return r & m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ov, rdy, bsy;
    logic [63:0] res;
    int lat, nrdy, pulses;

    rst_n = 1'b0; flush = 1'b0; v32 = 1'b0; v8 = 1'b0; v64 = 1'b0;
    set_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    peek(32, ov, rdy, bsy, res);
    check("reset out_valid", {63'd0, ov}, 64'd0);
    check("reset alu_out", res, 64'd0);
    check("reset busy", {63'd0, bsy}, 64'd0);
    check("reset in_ready", {63'd0, rdy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    peek(32, ov, rdy, bsy, res);
    check("post-reset in_ready", {63'd0, rdy}, 64'd1);

    // Back-to-back base ops: ADD, SUB, SRA with out-of-range shift bits.
    set_op(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 64'd5, 64'd7); v32 = 1'b1;
    @(negedge clk); peek(32, ov, rdy, bsy, res);
    check("b2b add valid", {63'd0, ov}, 64'd1); check("b2b add", res, 64'd12);
    set_op(2'b01, 3'd0, 1'b1, 1'b0, 1'b0, 64'd5, 64'd7);
    @(negedge clk); peek(32, ov, rdy, bsy, res);
    check("b2b sub valid", {63'd0, ov}, 64'd1); check("b2b sub", res, 64'hFFFF_FFFE);
    set_op(2'b01, 3'd5, 1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h24);
    @(negedge clk); peek(32, ov, rdy, bsy, res);
    check("b2b sra valid", {63'd0, ov}, 64'd1); check("b2b sra", res, 64'hF800_0000);
    check("b2b in_ready", {63'd0, rdy}, 64'd1);
    v32 = 1'b0;
    @(negedge clk); peek(32, ov, rdy, bsy, res);
    check("b2b single pulse", {63'd0, ov}, 64'd0);

    exec("pass op2", 32, 2'b10, 3'd3, 1'b1, 1'b1, 1'b0, 64'd1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1);
    exec("alu_op 11 add", 32, 2'b11, 3'd0, 1'b1, 1'b1, 1'b0, 64'd3, 64'd4, 64'd7, 1);
    exec("addi ignores i30", 32, 2'b01, 3'd0, 1'b1, 1'b0, 1'b1, 64'd10, 64'hFFFF_FFFF, 64'd9, 1);
    exec("srai", 32, 2'b01, 3'd5, 1'b1, 1'b1, 1'b1, 64'hF000_0000, 64'h404, 64'hFF00_0000, 1);
    exec("slt", 32, 2'b01, 3'd2, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'd1, 1);
    exec("sltu", 32, 2'b01, 3'd3, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF, 64'd1, 64'd0, 1);
    exec("xor", 32, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 1);
    exec("or", 32, 2'b01, 3'd6, 1'b0, 1'b0, 1'b0, 64'hF0F0, 64'hFF00, 64'hFFF0, 1);
    exec("and", 32, 2'b01, 3'd7, 1'b0, 1'b0, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    exec("undefined code adds", 32, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 64'd2, 64'd3, 64'd5, 1);

    run_op(32, 2'b01, 3'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFE, 64'd3, res, lat, nrdy);
    check("mulh result", res, 64'hFFFF_FFFF);
    check("mulh latency", 64'(lat), 64'd2);
    check("mulh ready low", 64'(nrdy), 64'd1);
    run_op(32, 2'b01, 3'd3, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, res, lat, nrdy);
    check("mulhu result", res, 64'hFFFF_FFFE);
    check("mulhu latency", 64'(lat), 64'd2);
    check("mulhu ready low", 64'(nrdy), 64'd1);
    exec("mul", 32, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFE, 64'd3, 64'hFFFF_FFFA, 2);
    exec("mulhsu", 32, 2'b01, 3'd2, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 2);

    run_op(32, 2'b01, 3'd4, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFF9, 64'd2, res, lat, nrdy);
    check("div -7/2", res, 64'hFFFF_FFFD);
    check("div latency", 64'(lat), 64'd34);
    check("div ready low", 64'(nrdy), 64'd33);
    exec("rem -7/2", 32, 2'b01, 3'd6, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 34);
    exec("divu by 0", 32, 2'b01, 3'd5, 1'b0, 1'b1, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF, 34);
    exec("remu by 0", 32, 2'b01, 3'd7, 1'b0, 1'b1, 1'b0, 64'd100, 64'd0, 64'd100, 34);
    exec("div overflow", 32, 2'b01, 3'd4, 1'b0, 1'b1, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 34);

    // Flush while idle drops the base-op result.
    @(negedge clk);
    set_op(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 64'd1, 64'd1); v32 = 1'b1; flush = 1'b1;
    @(negedge clk); v32 = 1'b0; flush = 1'b0;
    peek(32, ov, rdy, bsy, res);
    check("idle flush no valid", {63'd0, ov}, 64'd0);
    check("idle flush alu_out held", res, 64'h8000_0000);

    // Flush ten cycles into a DIVU, with an ADD presented in the flush cycle.
    @(negedge clk);
    set_op(2'b01, 3'd5, 1'b0, 1'b1, 1'b0, 64'd1000, 64'd3); v32 = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) v32 = 1'b0;
      peek(32, ov, rdy, bsy, res);
      if (ov) pulses++;
    end
    check("busy before flush", {63'd0, bsy}, 64'd1);
    set_op(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 64'd2, 64'd2); v32 = 1'b1; flush = 1'b1;
    @(negedge clk); v32 = 1'b0; flush = 1'b0;
    peek(32, ov, rdy, bsy, res);
    check("flush busy low", {63'd0, bsy}, 64'd0);
    check("flush in_ready", {63'd0, rdy}, 64'd1);
    check("flush alu_out held", res, 64'h8000_0000);
    for (int i = 0; i < 40; i++) begin
      peek(32, ov, rdy, bsy, res);
      if (ov) pulses++;
      @(negedge clk);
    end
    check("flush no out_valid", 64'(pulses), 64'd0);
    check("flushed add not accepted", res, 64'h8000_0000);

    // Reset the cycle after a MUL is accepted.
    set_op(2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 64'd6, 64'd7); v32 = 1'b1;
    @(negedge clk); v32 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    peek(32, ov, rdy, bsy, res);
    check("mul reset no valid", {63'd0, ov}, 64'd0);
    check("mul reset alu_out", res, 64'd0);
    check("mul reset in_ready low", {63'd0, rdy}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    peek(32, ov, rdy, bsy, res);
    check("mul reset in_ready after", {63'd0, rdy}, 64'd1);
    check("mul reset still no valid", {63'd0, ov}, 64'd0);

    // Width sweep: directed shift/divide corners, then model-checked random ops.
    exec("w8 sll 3-bit shamt", 8, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 64'd1, 64'h0B, 64'h08, 1);
    exec("w8 divu", 8, 2'b01, 3'd5, 1'b0, 1'b1, 1'b0, 64'd200, 64'd7, 64'h1C, 10);
    exec("w64 sll 6-bit shamt", 64, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 64'd1, 64'h47, 64'h80, 1);
    exec("w64 sll 63", 64, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 64'd1, 64'h3F, 64'h8000_0000_0000_0000, 1);
    exec("w64 div", 64, 2'b01, 3'd4, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
         64'hFFFF_FFFF_FFFF_FFF2, 66);

    for (int wi = 0; wi < 2; wi++) begin
      for (int k = 0; k < 30; k++) begin
        int w, elat;
        logic [1:0] aop;
        logic [2:0] f3;
        logic i30, i25, sel;
        logic [63:0] a, b;
        w   = (wi == 0) ? 8 : 64;
        aop = 2'($urandom_range(3));
        f3  = 3'($urandom_range(7));
        i30 = 1'($urandom_range(1));
        i25 = 1'($urandom_range(1));
        sel = ($urandom_range(3) == 0);
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        case ($urandom_range(7))
          0: b = 64'd0;
          1: begin a = 64'd1 << (w - 1); b = '1; end
          default: ;
        endcase
        if (k < 8) begin aop = 2'b01; i25 = 1'b1; sel = 1'b0; end
        elat = (aop == 2'b01 && !sel && i25) ? (f3[2] ? w + 2 : 2) : 1;
        exec($sformatf("w%0d rnd%0d", w, k), w, aop, f3, i30, i25, sel, a, b,
             ref_alu(w, aop, f3, i30, i25, sel, a, b), elat);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
